// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: make/break/extended prefix FSM, key-to-game-code map,
// held-key tracking and a show-ahead valid/ready press-event FIFO.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CODE_W     = 4,
  parameter int REPEAT_EN  = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    ps2_data,
  input  logic                          ps2_data_en,
  input  logic                          key_ready,
  output logic                          key_valid,
  output logic [CODE_W-1:0]             key_code,
  output logic [CODE_W-1:0]             held_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  state_t state, state_next;

  logic              make_evt;
  logic              brk_evt;
  logic              evt_ext;
  logic [CODE_W-1:0] evt_code;
  logic              evt_mapped;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              full;

  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Non-extended keypad bytes (75/72/6B/74) deliberately fall through to 0.
  function automatic logic [CODE_W-1:0] map_key(input logic [7:0] b, input logic ext);
    logic [CODE_W-1:0] c;
    c = '0;
    if (!ext) begin
      case (b)
        8'h16:   c = CODE_W'(1);
        8'h1E:   c = CODE_W'(2);
        8'h26:   c = CODE_W'(3);
        8'h25:   c = CODE_W'(4);
        8'h2D:   c = CODE_W'(5);
        8'h5A:   c = CODE_W'(10);
        8'h76:   c = CODE_W'(11);
        default: c = '0;
      endcase
    end else begin
      case (b)
        8'h75:   c = CODE_W'(6);
        8'h72:   c = CODE_W'(7);
        8'h6B:   c = CODE_W'(8);
        8'h74:   c = CODE_W'(9);
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A second E0 inside an extended sequence is a repeat prefix and keeps EXT.
  always_comb begin
    state_next = state;
    if (ps2_data_en) begin
      case (state)
        ST_IDLE: begin
          if (ps2_data == 8'hE0)      state_next = ST_EXT;
          else if (ps2_data == 8'hF0) state_next = ST_BRK;
          else                        state_next = ST_IDLE;
        end
        ST_EXT: begin
          if (ps2_data == 8'hF0)      state_next = ST_EXT_BRK;
          else if (ps2_data == 8'hE0) state_next = ST_EXT;
          else                        state_next = ST_IDLE;
        end
        ST_BRK:     state_next = ST_IDLE;
        ST_EXT_BRK: state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    make_evt = 1'b0;
    brk_evt  = 1'b0;
    evt_ext  = 1'b0;
    if (ps2_data_en) begin
      case (state)
        ST_IDLE: make_evt = (ps2_data != 8'hE0) && (ps2_data != 8'hF0);
        ST_EXT: begin
          make_evt = (ps2_data != 8'hE0) && (ps2_data != 8'hF0);
          evt_ext  = 1'b1;
        end
        ST_BRK: brk_evt = 1'b1;
        ST_EXT_BRK: begin
          brk_evt = 1'b1;
          evt_ext = 1'b1;
        end
        default: make_evt = 1'b0;
      endcase
    end
  end

  assign evt_code   = map_key(ps2_data, evt_ext);
  assign evt_mapped = (evt_code != '0);
  assign push_req   = make_evt && evt_mapped &&
                      ((REPEAT_EN != 0) || (evt_code != held_code));

  assign key_valid = (fifo_count != '0);
  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop       = key_valid && key_ready;
  assign push_ok   = push_req && (!full || pop);
  assign key_code  = key_valid ? mem[rd_ptr] : '0;

  // Releasing a key other than the held one leaves held_code alone.
  always_ff @(posedge clock) begin
    if (reset)
      held_code <= '0;
    else if (make_evt && evt_mapped)
      held_code <= evt_code;
    else if (brk_evt && evt_mapped && (evt_code == held_code))
      held_code <= '0;
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= evt_code;
  end

  // A push into a full FIFO only succeeds when the head leaves the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push_ok && pop) fifo_count <= fifo_count - 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: vector table plus hand-written
// FIFO/reset sequences, with a queue scoreboard checking every popped event.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ps2_data;
  logic       ps2_data_en;
  logic       key_ready;
  logic       key_ready_r;

  logic       key_valid,   key_valid_r;
  logic [3:0] key_code,    key_code_r;
  logic [3:0] held_code,   held_code_r;
  logic [2:0] fifo_count,  fifo_count_r;
  logic       overflow,    overflow_r;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q [$];

  typedef struct {
    logic [7:0] data;
    bit         push;
    logic [3:0] code;
    logic [3:0] held;
  } vec_t;

  vec_t vecs [$];

  always #10 clock = ~clock;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CODE_W(4), .REPEAT_EN(0)) dut (
    .clock(clock), .reset(reset), .ps2_data(ps2_data), .ps2_data_en(ps2_data_en),
    .key_ready(key_ready), .key_valid(key_valid), .key_code(key_code),
    .held_code(held_code), .fifo_count(fifo_count), .overflow(overflow)
  );

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CODE_W(4), .REPEAT_EN(1)) dut_rep (
    .clock(clock), .reset(reset), .ps2_data(ps2_data), .ps2_data_en(ps2_data_en),
    .key_ready(key_ready_r), .key_valid(key_valid_r), .key_code(key_code_r),
    .held_code(held_code_r), .fifo_count(fifo_count_r), .overflow(overflow_r)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard: every event the consumer takes must match the oldest expected one.
  always @(negedge clock) begin
    if (!reset && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_event: got %0d, expected none", key_code);
      end else begin
        checkOutput("pop_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic applyReset();
    @(posedge clock); #1;
    reset = 1'b1;
    ps2_data_en = 1'b0;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit push, input logic [3:0] code);
    @(posedge clock); #1;
    if (push) exp_q.push_back(code);
    ps2_data    = d;
    ps2_data_en = 1'b1;
    @(posedge clock); #1;
    ps2_data_en = 1'b0;
    @(negedge clock);
  endtask

  task automatic drain(input string name);
    @(posedge clock); #1;
    key_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !key_valid) break;
    end
    @(posedge clock); #1;
    key_ready = 1'b0;
    @(negedge clock);
    checkOutput({name, "_pending"}, exp_q.size(), 0);
    checkOutput({name, "_valid"}, key_valid, 0);
    checkOutput({name, "_count"}, fifo_count, 0);
  endtask

  function automatic void addVec(input logic [7:0] d, input bit p, input logic [3:0] c, input logic [3:0] h);
    vec_t v;
    v.data = d; v.push = p; v.code = c; v.held = h;
    vecs.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; ps2_data = 8'h00; ps2_data_en = 1'b0;
    key_ready = 1'b0; key_ready_r = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_valid", key_valid, 0);
    checkOutput("rst_code", key_code, 0);
    checkOutput("rst_held", held_code, 0);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_overflow", overflow, 0);

    // Single press, consumer accepts for exactly one cycle.
    applyStimulus(8'h16, 1, 4'd1);
    checkOutput("t1_valid", key_valid, 1);
    checkOutput("t1_code", key_code, 1);
    checkOutput("t1_held", held_code, 1);
    @(posedge clock); #1 key_ready = 1'b1;
    @(posedge clock); #1 key_ready = 1'b0;
    @(negedge clock);
    checkOutput("t1_popped", key_valid, 0);

    // Table-driven sequence with the consumer always ready.
    applyReset();
    addVec(8'h16, 1, 4'd1, 4'd1);  addVec(8'hE0, 0, 4'd0, 4'd1);
    addVec(8'h75, 1, 4'd6, 4'd6);  addVec(8'hE0, 0, 4'd0, 4'd6);
    addVec(8'hF0, 0, 4'd0, 4'd6);  addVec(8'h75, 0, 4'd0, 4'd0);
    addVec(8'h1E, 1, 4'd2, 4'd2);  addVec(8'h1E, 0, 4'd0, 4'd2);
    addVec(8'h1E, 0, 4'd0, 4'd2);  addVec(8'hF0, 0, 4'd0, 4'd2);
    addVec(8'h16, 0, 4'd0, 4'd2);  addVec(8'hF0, 0, 4'd0, 4'd2);
    addVec(8'h1E, 0, 4'd0, 4'd0);  addVec(8'h1E, 1, 4'd2, 4'd2);
    addVec(8'h1C, 0, 4'd0, 4'd2);  addVec(8'h75, 0, 4'd0, 4'd2);
    addVec(8'hE1, 0, 4'd0, 4'd2);  addVec(8'hE0, 0, 4'd0, 4'd2);
    addVec(8'h6B, 1, 4'd8, 4'd8);  addVec(8'hE0, 0, 4'd0, 4'd8);
    addVec(8'hE0, 0, 4'd0, 4'd8);  addVec(8'h72, 1, 4'd7, 4'd7);
    addVec(8'h5A, 1, 4'd10, 4'd10); addVec(8'h76, 1, 4'd11, 4'd11);
    addVec(8'h26, 1, 4'd3, 4'd3);  addVec(8'h25, 1, 4'd4, 4'd4);
    addVec(8'h2D, 1, 4'd5, 4'd5);  addVec(8'hE0, 0, 4'd0, 4'd5);
    addVec(8'h74, 1, 4'd9, 4'd9);  addVec(8'hE0, 0, 4'd0, 4'd9);
    addVec(8'hF0, 0, 4'd0, 4'd9);  addVec(8'h74, 0, 4'd0, 4'd0);
    addVec(8'hF0, 0, 4'd0, 4'd0);  addVec(8'h2D, 0, 4'd0, 4'd0);
    @(posedge clock); #1 key_ready = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data, vecs[i].push, vecs[i].code);
      checkOutput($sformatf("vec%0d_held", i), held_code, vecs[i].held);
    end
    drain("table");

    // Typematic repeats: suppressed in one instance, queued in the other.
    applyReset();
    key_ready_r = 1'b0;
    applyStimulus(8'h1E, 1, 4'd2);
    applyStimulus(8'h1E, 0, 4'd0);
    applyStimulus(8'h1E, 0, 4'd0);
    checkOutput("rep0_count", fifo_count, 1);
    checkOutput("rep1_count", fifo_count_r, 3);
    checkOutput("rep1_valid", key_valid_r, 1);
    checkOutput("rep1_code", key_code_r, 2);
    checkOutput("rep1_held", held_code_r, 2);
    checkOutput("rep1_overflow", overflow_r, 0);
    applyStimulus(8'hF0, 0, 4'd0);
    applyStimulus(8'h1E, 0, 4'd0);
    applyStimulus(8'h1E, 1, 4'd2);
    checkOutput("rep0_count2", fifo_count, 2);
    key_ready_r = 1'b1;
    drain("repeat");

    // Overflow: fifth press into a full FIFO is dropped.
    applyReset();
    applyStimulus(8'h16, 1, 4'd1);
    applyStimulus(8'h1E, 1, 4'd2);
    applyStimulus(8'h26, 1, 4'd3);
    applyStimulus(8'h25, 1, 4'd4);
    applyStimulus(8'h2D, 0, 4'd0);
    checkOutput("ovf_count", fifo_count, 4);
    checkOutput("ovf_flag", overflow, 1);
    drain("ovf");
    checkOutput("ovf_sticky", overflow, 1);
    applyReset();
    checkOutput("ovf_cleared", overflow, 0);

    // Full FIFO with simultaneous push and pop.
    applyStimulus(8'h16, 1, 4'd1);
    applyStimulus(8'h1E, 1, 4'd2);
    applyStimulus(8'h26, 1, 4'd3);
    applyStimulus(8'h25, 1, 4'd4);
    checkOutput("full_count", fifo_count, 4);
    @(posedge clock); #1;
    exp_q.push_back(4'd5);
    key_ready = 1'b1; ps2_data = 8'h2D; ps2_data_en = 1'b1;
    @(posedge clock); #1;
    key_ready = 1'b0; ps2_data_en = 1'b0;
    @(negedge clock);
    checkOutput("pushpop_count", fifo_count, 4);
    checkOutput("pushpop_overflow", overflow, 0);
    drain("pushpop");

    // Reset mid-sequence discards the E0 prefix and any strobe during reset.
    applyReset();
    applyStimulus(8'hE0, 0, 4'd0);
    @(posedge clock); #1;
    reset = 1'b1; exp_q.delete();
    ps2_data = 8'h16; ps2_data_en = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; ps2_data_en = 1'b0;
    @(negedge clock);
    checkOutput("midrst_count", fifo_count, 0);
    applyStimulus(8'h75, 0, 4'd0);
    checkOutput("keypad_count", fifo_count, 0);
    checkOutput("keypad_held", held_code, 0);
    applyStimulus(8'h1C, 0, 4'd0);
    checkOutput("unmapped_count", fifo_count, 0);
    applyStimulus(8'h1E, 1, 4'd2);
    checkOutput("idle_held", held_code, 2);
    checkOutput("idle_count", fifo_count, 1);

    // Releasing a different key leaves the held key in place.
    applyStimulus(8'hF0, 0, 4'd0);
    applyStimulus(8'h16, 0, 4'd0);
    checkOutput("other_brk_held", held_code, 2);
    applyStimulus(8'hF0, 0, 4'd0);
    applyStimulus(8'h1E, 0, 4'd0);
    checkOutput("own_brk_held", held_code, 0);
    drain("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
